csla_pipe_adder: RTL and testbench

- Parametrised, two-stage pipelined carry-select adder/subtractor. Successor to the fixed 3-bit carry-lookahead segment.
- Splits a WIDTH-bit operand into SEG-bit lookahead segments. Each segment precomputes its result for carry-in 0 and carry-in 1. A second stage selects the correct result through the segment chain.
- Used for final-sum accumulation of multiplier partial products. Uses a valid/ready handshake so it can sit in a stallable datapath.

---
 rtl/csla_pkg.sv | 23 ++
 rtl/csla_pipe_adder_cla_segment.sv | 32 +++
 rtl/csla_pipe_adder.sv | 180 ++++++++++++++++++
 tb/tb_csla_pipe_adder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/csla_pkg.sv
// Shared constants, types and helpers for the pipelined carry-select adder.
package csla_pkg;

  // Default datapath geometry: 16-bit operands split into 4-bit segments.
  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;
  localparam int NSEG      = DEF_WIDTH / DEF_SEG;

  // Stage-1 storage for one segment at the default geometry: the result
  // precomputed for carry-in 0 and for carry-in 1.
  typedef struct packed {
    logic [DEF_SEG-1:0] sum0;
    logic [DEF_SEG-1:0] sum1;
    logic               c0;
    logic               c1;
  } seg_res_t;

  // Number of segments for an arbitrary geometry.
  function automatic int seg_count(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/csla_pipe_adder_cla_segment.sv
// One SEG-bit carry-lookahead segment: generate/propagate with a rippled
// lookahead recurrence, purely combinational.
module cla_segment
  import csla_pkg::*;
#(
  parameter int SEG = DEF_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic [SEG-1:0] p;
  logic [SEG-1:0] g;
  logic [SEG:0]   c;

  // Lookahead recurrence C(i+1) = G(i) | P(i) & C(i), then S = P ^ C.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum  = p ^ c[SEG-1:0];
    cout = c[SEG];
  end

endmodule

// File: rtl/csla_pipe_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready flow
// control. Stage 1 precomputes every segment for both carry-in values;
// stage 2 resolves the carry chain and registers sum, cout and ovf.
module csla_pipe_adder
  import csla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NS = seg_count(WIDTH, SEG);

  if ((SEG < 1) || (SEG > WIDTH) || ((WIDTH % SEG) != 0)) begin : g_param_check
    $error("csla_pipe_adder: WIDTH must be a positive integer multiple of SEG");
  end

  typedef struct packed {
    logic [SEG-1:0] sum0;
    logic [SEG-1:0] sum1;
    logic           c0;
    logic           c1;
  } seg_slot_t;

  // Operand preparation
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : cin;

  // Stage-1 combinational segment results
  logic [NS-1:0][SEG-1:0] seg_sum0;
  logic [NS-1:0][SEG-1:0] seg_sum1;
  logic [NS-1:0]          seg_c0;
  logic [NS-1:0]          seg_c1;

  for (genvar k = 0; k < NS; k++) begin : g_seg
    if (k == 0) begin : g_low
      // The real carry-in is known up front, so only one evaluation is needed.
      // The carry-in-1 slot is tied off and never selected in stage 2.
      cla_segment #(.SEG(SEG)) u_cla (
        .a    (a[SEG-1:0]),
        .b    (b_eff[SEG-1:0]),
        .cin  (c_eff),
        .sum  (seg_sum0[k]),
        .cout (seg_c0[k])
      );
      assign seg_sum1[k] = '0;
      assign seg_c1[k]   = 1'b0;
    end else begin : g_high
      cla_segment #(.SEG(SEG)) u_cla0 (
        .a    (a[k*SEG +: SEG]),
        .b    (b_eff[k*SEG +: SEG]),
        .cin  (1'b0),
        .sum  (seg_sum0[k]),
        .cout (seg_c0[k])
      );
      cla_segment #(.SEG(SEG)) u_cla1 (
        .a    (a[k*SEG +: SEG]),
        .b    (b_eff[k*SEG +: SEG]),
        .cin  (1'b1),
        .sum  (seg_sum1[k]),
        .cout (seg_c1[k])
      );
    end
  end

  seg_slot_t [NS-1:0] slot_d;
  seg_slot_t [NS-1:0] slot_q;

  // Pack the per-segment results into stage-1 storage format.
  always_comb begin
    slot_d = '0;
    for (int k = 0; k < NS; k++) begin
      slot_d[k].sum0 = seg_sum0[k];
      slot_d[k].sum1 = seg_sum1[k];
      slot_d[k].c0   = seg_c0[k];
      slot_d[k].c1   = seg_c1[k];
    end
  end

  // Flow control
  logic v1_q;
  logic a_msb_q;
  logic b_msb_q;
  logic out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic cout_q;
  logic ovf_q;
  logic adv1;
  logic adv2;
  logic accept;

  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign accept   = in_valid && adv1;
  assign in_ready = adv1;

  // Stage 1: capture precomputed segment results and sign bits on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      slot_q  <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      if (adv1) begin
        v1_q <= in_valid;
      end
      if (accept) begin
        slot_q  <= slot_d;
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b_eff[WIDTH-1];
      end
    end
  end

  // Stage 2 combinational carry select
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             carry;

  // Walk the chain from segment 0 upward. Segment 0 already absorbed the real
  // carry-in, so the chain starts with carry 0 and picks its sum0/c0 slot.
  always_comb begin
    sum_d = '0;
    carry = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (carry) begin
        sum_d[k*SEG +: SEG] = slot_q[k].sum1;
        carry               = slot_q[k].c1;
      end else begin
        sum_d[k*SEG +: SEG] = slot_q[k].sum0;
        carry               = slot_q[k].c0;
      end
    end
    cout_d = carry;
    ovf_d  = (a_msb_q == b_msb_q) && (sum_d[WIDTH-1] != a_msb_q);
  end

  // Stage 2: register the resolved result when the output slot can advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (adv2) begin
        out_valid_q <= v1_q;
      end
      if (adv2 && v1_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_csla_pipe_adder.sv
// Self-checking bench for csla_pipe_adder at WIDTH=16, SEG=4.
module tb_csla_pipe_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  csla_pipe_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, sum}
  function automatic logic [17:0] ref_model(input logic [15:0] va, input logic [15:0] vb,
                                            input logic vcin, input logic vsub);
    logic [15:0] be;
    logic        ce;
    logic [16:0] full;
    logic        o;
    be   = vsub ? ~vb : vb;
    ce   = vsub ? 1'b1 : vcin;
    full = {1'b0, va} + {1'b0, be} + {16'd0, ce};
    o    = (va[15] == be[15]) && (full[15] != va[15]);
    return {o, full};
  endfunction

  // Single beat through an empty pipe; entered and left at posedge+1.
  task automatic run_vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vcin, input logic vsub, input logic [15:0] es,
                         input logic ec, input logic eo);
    int n;
    a = va; b = vb; cin = vcin; sub = vsub;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 32'd1);
    chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [15:0] bp_a [4];
  logic [15:0] bp_b [4];
  logic [15:0] bp_s [4];
  logic [17:0] q [$];

  initial begin
    int idx;
    int got;
    int seen;
    int first_c;
    int last_c;
    logic [17:0] e;

    rst = 1'b1; in_valid = 1'b0; a = 16'd0; b = 16'd0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("init_ov", {31'd0, out_valid}, 32'd0);
    chk("init_sum", {16'd0, sum}, 32'd0);
    chk("init_rdy", {31'd0, in_ready}, 32'd1);

    // Directed vectors
    run_vec("carry12", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_vec("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_vec("sovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_vec("subovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_vec("borrow",  16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_vec("cin",     16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    run_vec("cin8",    16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);

    // Reset mid-stream with two beats in flight
    out_ready = 1'b0; in_valid = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    a = 16'h0002; b = 16'h0002;
    @(posedge clk); #1;
    chk("rst_pre_ov", {31'd0, out_valid}, 32'd1);
    chk("rst_pre_rdy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("rst_ghost", seen, 32'd0);

    // Backpressure: four beats offered while the output is blocked
    bp_a[0] = 16'h0011; bp_b[0] = 16'h0001; bp_s[0] = 16'h0012;
    bp_a[1] = 16'h0022; bp_b[1] = 16'h0002; bp_s[1] = 16'h0024;
    bp_a[2] = 16'h0033; bp_b[2] = 16'h0003; bp_s[2] = 16'h0036;
    bp_a[3] = 16'h0044; bp_b[3] = 16'h0004; bp_s[3] = 16'h0048;
    out_ready = 1'b0; idx = 0; cin = 1'b0; sub = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin a = bp_a[idx]; b = bp_b[idx]; end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      if (c >= 1) begin
        chk("bp_hold_ov", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_sum", {16'd0, sum}, {16'd0, bp_s[0]});
      end
    end
    chk("bp_accepts", idx, 32'd2);
    chk("bp_rdy", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; got = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 12 && got < 4; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin a = bp_a[idx]; b = bp_b[idx]; end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        chk("bp_order", {16'd0, sum}, {16'd0, bp_s[got]});
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_count", got, 32'd4);
    chk("bp_span", last_c - first_c, 32'd3);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("bp_extra", seen, 32'd0);

    // Random stream against the reference model
    for (int c = 0; c < 10000; c++) begin
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) q.push_back(ref_model(a, b, cin, sub));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_spurious", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rnd_result", {14'd0, ovf, cout, sum}, {14'd0, e});
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_spurious", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rnd_result", {14'd0, ovf, cout, sum}, {14'd0, e});
        end
      end
      @(posedge clk); #1;
    end
    chk("rnd_left", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
